// File: rtl/seg7_pkg.sv
// Shared constants and the hex-to-segment lookup for the seven-segment scanner.
package seg7_pkg;

  // Segment bus {g,f,e,d,c,b,a}, active low: all ones = every segment dark.
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // All-ones anode pattern; slice to the digit count in use.
  localparam int MAX_DIGITS = 32;
  localparam logic [MAX_DIGITS-1:0] AN_OFF = '1;

  // Active-low segment pattern for one hex nibble.
  function automatic logic [6:0] hex2seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to active-low seven-segment pattern.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = hex2seg(nibble);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed seven-segment scanner with frame-synchronous update,
// per-digit enable, leading-zero blanking, decimal points and PWM brightness.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int CLK_DIV    = 1024,
  parameter int DUTY_W     = 11
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    lz_blank,
  input  logic [DUTY_W-1:0]       duty,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg7,
  output logic                    dp,
  output logic                    frame_done
);

  localparam int TICK_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CMP_W  = (TICK_W > DUTY_W) ? TICK_W : DUTY_W;
  localparam logic [TICK_W-1:0]     TICK_LAST = TICK_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_ONE    = NUM_DIGITS'(1);
  localparam logic [NUM_DIGITS-1:0] AN_NONE   = AN_OFF[NUM_DIGITS-1:0];

  logic [TICK_W-1:0]       tick;
  logic [IDX_W-1:0]        idx;
  logic [4*NUM_DIGITS-1:0] hold_data, disp_data;
  logic [NUM_DIGITS-1:0]   hold_dp, disp_dp;
  logic [DUTY_W-1:0]       duty_q;
  logic                    slot_end, frame_end;

  logic [NUM_DIGITS-1:0]   lz;
  logic                    zero_run;
  logic [3:0]              cur_nib;
  logic                    cur_dp, cur_en, cur_lz;
  logic [6:0]              cur_seg;
  logic                    lit;

  logic [NUM_DIGITS-1:0]   an_q;
  logic [6:0]              seg_q;
  logic                    dp_q, fd_q;

  assign slot_end  = (tick == TICK_LAST);
  assign frame_end = slot_end && (idx == IDX_LAST);

  // Prescaler and digit index: one slot of CLK_DIV clocks per digit.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick <= '0;
      idx  <= '0;
    end else begin
      tick <= slot_end ? '0 : tick + 1'b1;
      if (slot_end) idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end
  end

  // Hold registers take loads any time; display registers only change at frame end,
  // with a load on that same cycle bypassing straight into the display copy.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_data <= '0;
      hold_dp   <= '0;
      disp_data <= '0;
      disp_dp   <= '0;
      duty_q    <= '0;
    end else begin
      if (load) begin
        hold_data <= data_in;
        hold_dp   <= dp_in;
      end
      if (frame_end) begin
        disp_data <= load ? data_in : hold_data;
        disp_dp   <= load ? dp_in   : hold_dp;
        duty_q    <= duty;
      end
    end
  end

  // Leading-zero chain from the most significant digit down; digit 0 is never blanked.
  always_comb begin
    zero_run = 1'b1;
    lz       = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run && (disp_data[4*i +: 4] == 4'h0);
      lz[i]    = lz_blank && (i != 0) && zero_run;
    end
  end

  // Select the attributes of the digit currently being scanned.
  always_comb begin
    cur_nib = 4'h0;
    cur_dp  = 1'b0;
    cur_en  = 1'b0;
    cur_lz  = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_nib = disp_data[4*i +: 4];
        cur_dp  = disp_dp[i];
        cur_en  = digit_en[i];
        cur_lz  = lz[i];
      end
    end
  end

  seg7_hex_decode u_decode (
    .nibble (cur_nib),
    .seg    (cur_seg)
  );

  assign lit = cur_en && !cur_lz && (CMP_W'(tick) < CMP_W'(duty_q));

  // Registered outputs; anode and segments switch on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      an_q  <= AN_NONE;
      seg_q <= SEG_OFF;
      dp_q  <= 1'b1;
      fd_q  <= 1'b0;
    end else begin
      an_q  <= lit ? ~(AN_ONE << idx) : AN_NONE;
      seg_q <= lit ? cur_seg : SEG_OFF;
      dp_q  <= lit ? ~cur_dp : 1'b1;
      fd_q  <= frame_end;
    end
  end

  assign an         = an_q;
  assign seg7       = seg_q;
  assign dp         = dp_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with 4 digits and 4-clock slots.
module tb_seg7_scan_ctrl;

  localparam int ND = 4;
  localparam int CD = 4;
  localparam int DW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          load;
  logic [15:0]   data_in;
  logic [3:0]    dp_in;
  logic [3:0]    digit_en;
  logic          lz_blank;
  logic [DW-1:0] duty;
  logic [3:0]    an;
  logic [6:0]    seg7;
  logic          dp;
  logic          frame_done;

  int checks = 0;
  int fails  = 0;

  // Active-low hex patterns, indexed by nibble value.
  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  seg7_scan_ctrl #(.NUM_DIGITS(ND), .CLK_DIV(CD), .DUTY_W(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .data_in    (data_in),
    .dp_in      (dp_in),
    .digit_en   (digit_en),
    .lz_blank   (lz_blank),
    .duty       (duty),
    .an         (an),
    .seg7       (seg7),
    .dp         (dp),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check_onehot(input string tag);
    checks++;
    assert ($countones(~an) <= 1)
      else begin fails++; $error("FAIL %s onehot: an=%h has more than one low", tag, an); end
  endtask

  task automatic check_off(input string tag);
    checks++;
    assert (an === 4'hF) else begin fails++; $error("FAIL %s an: got %h exp F", tag, an); end
    checks++;
    assert (seg7 === 7'h7F) else begin fails++; $error("FAIL %s seg7: got %h exp 7F", tag, seg7); end
    checks++;
    assert (dp === 1'b1) else begin fails++; $error("FAIL %s dp: got %b exp 1", tag, dp); end
    checks++;
    assert (frame_done === 1'b0)
      else begin fails++; $error("FAIL %s frame_done: got %b exp 0", tag, frame_done); end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] p);
    load = 1'b1; data_in = v; dp_in = p;
    step();
    load = 1'b0;
  endtask

  // Advance until a frame_done cycle, bounded.
  task automatic wait_fd(input string tag, output int n);
    n = 0;
    while (frame_done !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    checks++;
    assert (frame_done === 1'b1)
      else begin fails++; $error("FAIL %s wait_fd: frame_done not seen in %0d clks", tag, n); end
  endtask

  // Called on a frame_done cycle: checks the 16 slot-cycles of the frame that starts now.
  // mask = digits expected lit, dpx = digits with dp expected lit, lit_n = lit ticks per slot.
  // Optionally drives a one-cycle load after sample load_at.
  task automatic check_frame(input string tag, input logic [15:0] d, input logic [3:0] mask,
                             input logic [3:0] dpx, input int lit_n, input int load_at,
                             input logic [15:0] lval, input logic [3:0] ldp);
    logic [3:0] one;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp, e_fd, e_lit;
    int di, t;
    one = 4'b0001;
    for (int j = 0; j < 16; j++) begin
      step();
      load = 1'b0;
      di = j / 4;
      t  = j % 4;
      e_lit = mask[di] && (t < lit_n);
      e_an  = e_lit ? ~(one << di) : 4'hF;
      e_seg = e_lit ? hex_tab[d[di*4 +: 4]] : 7'h7F;
      e_dp  = e_lit ? ~dpx[di] : 1'b1;
      e_fd  = (j == 15);
      checks++;
      assert (an === e_an)
        else begin fails++; $error("FAIL %s an[s%0d]: got %h exp %h", tag, j, an, e_an); end
      checks++;
      assert (seg7 === e_seg)
        else begin fails++; $error("FAIL %s seg7[s%0d]: got %h exp %h", tag, j, seg7, e_seg); end
      checks++;
      assert (dp === e_dp)
        else begin fails++; $error("FAIL %s dp[s%0d]: got %b exp %b", tag, j, dp, e_dp); end
      checks++;
      assert (frame_done === e_fd)
        else begin fails++; $error("FAIL %s frame_done[s%0d]: got %b exp %b", tag, j, frame_done, e_fd); end
      check_onehot(tag);
      if (j == load_at) begin
        load = 1'b1; data_in = lval; dp_in = ldp;
      end
    end
  endtask

  initial begin
    int n;
    reset = 1'b1; load = 1'b0; data_in = '0; dp_in = '0;
    digit_en = 4'hF; lz_blank = 1'b0; duty = 3'd4;
    step(); step(); step();
    check_off("reset");

    // 1: basic scan of 12AF at full duty
    reset = 1'b0;
    do_load(16'h12AF, 4'h0);
    wait_fd("t1", n);
    checks++;
    assert (n == 15) else begin fails++; $error("FAIL t1 first_frame: got %0d clks exp 15", n); end
    check_frame("t1", 16'h12AF, 4'hF, 4'h0, 4, -1, '0, '0);

    // 2: leading-zero blanking
    lz_blank = 1'b1;
    do_load(16'h0030, 4'h0);
    wait_fd("t2a", n);
    check_frame("t2a", 16'h0030, 4'b0011, 4'h0, 4, -1, '0, '0);
    do_load(16'h0000, 4'h0);
    wait_fd("t2b", n);
    check_frame("t2b", 16'h0000, 4'b0001, 4'h0, 4, -1, '0, '0);

    // 3: mid-frame load is deferred; load on frame_end bypasses to the next frame
    lz_blank = 1'b0;
    check_frame("t3a", 16'h0000, 4'hF, 4'h0, 4, 4, 16'h5555, 4'h0);
    check_frame("t3b", 16'h5555, 4'hF, 4'h0, 4, 14, 16'h8B6D, 4'h0);

    // 4: duty changes take effect only at frame end
    duty = 3'd1;
    check_frame("t4a", 16'h8B6D, 4'hF, 4'h0, 4, -1, '0, '0);
    duty = 3'd0;
    check_frame("t4b", 16'h8B6D, 4'hF, 4'h0, 1, -1, '0, '0);
    duty = 3'd7;
    check_frame("t4c", 16'h8B6D, 4'hF, 4'h0, 0, -1, '0, '0);
    check_frame("t4d", 16'h8B6D, 4'hF, 4'h0, 4, -1, '0, '0);

    // 5: live digit enable, frame-synchronous decimal points
    digit_en = 4'b0101;
    check_frame("t5a", 16'h8B6D, 4'b0101, 4'h0, 4, 0, 16'h8B6D, 4'b0001);
    check_frame("t5b", 16'h8B6D, 4'b0101, 4'b0001, 4, -1, '0, '0);

    // 6: reset at idx=2, tick=3
    for (int k = 0; k < 11; k++) begin
      step();
      check_onehot("t6pre");
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    digit_en = 4'hF; duty = 3'd4; dp_in = 4'h0;
    check_off("t6rst");
    wait_fd("t6", n);
    checks++;
    assert (n == 16) else begin fails++; $error("FAIL t6 restart: got %0d clks exp 16", n); end
    check_frame("t6", 16'h0000, 4'hF, 4'h0, 4, -1, '0, '0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
